// File: rtl/tt_capture.sv
// tt_capture: steps a 3-input DUT through all 8 input vectors, waits SETTLE
// cycles per vector, captures the response as a truth table and compares it
// against a golden table.
module tt_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    input  logic [7:0] expected,
    output logic [2:0] abc_out,
    output logic [7:0] tt_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] ones_cnt
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             go;
    logic             capture;
    logic             quit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle control strobes; abort beats a same-cycle capture
    always_comb begin
        state_n = state;
        go      = 1'b0;
        capture = 1'b0;
        quit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WAIT;
                    go      = 1'b1;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_n = S_IDLE;
                    quit    = 1'b1;
                end else if (cnt == '0) begin
                    state_n = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_n = S_IDLE;
                    quit    = 1'b1;
                end else begin
                    capture = 1'b1;
                    state_n = (abc_out == 3'd7) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: vector stepping, settle counter, capture and verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abc_out  <= '0;
            tt_out   <= '0;
            ones_cnt <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            busy <= (state_n == S_WAIT) || (state_n == S_SAMPLE);
            done <= (state_n == S_DONE);

            if (go) begin
                abc_out  <= '0;
                tt_out   <= '0;
                ones_cnt <= '0;
                pass     <= 1'b0;
                cnt      <= RELOAD;
            end

            if (state == S_WAIT && !abort && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (capture) begin
                tt_out[abc_out] <= y_in;
                if (y_in) begin
                    ones_cnt <= ones_cnt + 4'd1;
                end
                // last vector stays on the bus until the next scan
                if (abc_out != 3'd7) begin
                    abc_out <= abc_out + 3'd1;
                    cnt     <= RELOAD;
                end
            end

            if (quit) begin
                pass <= 1'b0;
            end

            if (state == S_DONE) begin
                pass <= (tt_out == expected);
            end
        end
    end

endmodule

// File: tb/tb_tt_capture.sv
// tb_tt_capture: randomized scans on SETTLE=2 and SETTLE=1 instances against a
// timeline model (vector index and phase derived from cycles since start).
module tb_tt_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       abort;
    logic [7:0] expected;
    logic       start2, start1, y2, y1;
    logic [2:0] abc2, abc1;
    logic [7:0] tt2, tt1;
    logic       busy2, busy1, done2, done1, pass2, pass1;
    logic [3:0] ones2, ones1;

    tt_capture #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .y_in(y2),
        .expected(expected), .abc_out(abc2), .tt_out(tt2), .busy(busy2),
        .done(done2), .pass(pass2), .ones_cnt(ones2)
    );

    tt_capture #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .y_in(y1),
        .expected(expected), .abc_out(abc1), .tt_out(tt1), .busy(busy1),
        .done(done1), .pass(pass1), .ones_cnt(ones1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] o_abc;
    logic [7:0] o_tt;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_ones;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // copy outputs of the selected instance (sel=1 -> SETTLE=1)
    task automatic grab(input int sel);
        if (sel != 0) begin
            o_abc = abc1; o_tt = tt1; o_busy = busy1; o_done = done1; o_pass = pass1; o_ones = ones1;
        end else begin
            o_abc = abc2; o_tt = tt2; o_busy = busy2; o_done = done2; o_pass = pass2; o_ones = ones2;
        end
    endtask

    task automatic set_y(input int sel, input logic v);
        if (sel != 0) begin y1 = v; y2 = 1'b0; end
        else begin y2 = v; y1 = 1'b0; end
    endtask

    task automatic set_start(input int sel, input logic v);
        start1 = (sel != 0) ? v : 1'b0;
        start2 = (sel != 0) ? 1'b0 : v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_abc"},  32'(o_abc),  32'd0);
        check({tag, "_tt"},   32'(o_tt),   32'd0);
        check({tag, "_ones"}, 32'(o_ones), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_pass"}, 32'(o_pass), 32'd0);
    endtask

    // One scan: func is the response truth table, abort_k/late_c/rst_k < 0 disable.
    task automatic scan(input int sel, input logic [7:0] func, input logic [7:0] exp_v,
                        input int abort_k, input bit noise, input int late_c, input int rst_k);
        int         p;
        int         last;
        int         k;
        bit         smp;
        bit         saw_done;
        logic [7:0] mtt;
        p    = ((sel != 0) ? 1 : 2) + 1;
        last = 8 * p + 1;
        mtt  = 8'h00;
        @(posedge clk); #1;
        abort    = 1'b0;
        expected = exp_v;
        set_start(sel, 1'b1);
        set_y(sel, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        for (int c = 1; c <= last + 3; c++) begin
            k   = (c - 1) / p;
            smp = (c < last) && (((c - 1) % p) == p - 1);
            set_start(sel, 1'b0);
            abort = 1'b0;
            grab(sel);
            if (c < last) begin
                check("abc", 32'(o_abc), 32'(k));
                check("busy", 32'(o_busy), 32'd1);
                check("done", 32'(o_done), 32'd0);
            end else if (c == last) begin
                check("abc_done", 32'(o_abc), 32'd7);
                check("busy_done", 32'(o_busy), 32'd0);
                check("done_pulse", 32'(o_done), 32'd1);
            end else begin
                check("abc_hold", 32'(o_abc), 32'd7);
                check("busy_idle", 32'(o_busy), 32'd0);
                check("done_idle", 32'(o_done), 32'd0);
                check("pass", 32'(o_pass), 32'(mtt == exp_v));
            end
            check("tt", 32'(o_tt), 32'(mtt));
            check("ones", 32'(o_ones), 32'($countones(mtt)));

            if (rst_k == k && c < last && ((c - 1) % p) == 0) begin
                #2 rst = 1'b1;
                #1 grab(sel);
                check_zero("async_rst");
                #1 rst = 1'b0;
                return;
            end

            if (smp) set_y(sel, func[k]);
            else if (noise || c >= last) set_y(sel, 1'($urandom_range(0, 1)));
            else set_y(sel, func[k]);

            if (smp && k == abort_k) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                grab(sel);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_done", 32'(o_done), 32'd0);
                check("abort_pass", 32'(o_pass), 32'd0);
                check("abort_abc", 32'(o_abc), 32'(k));
                check("abort_tt", 32'(o_tt), 32'(mtt));
                check("abort_ones", 32'(o_ones), 32'($countones(mtt)));
                saw_done = 1'b0;
                for (int j = 0; j < 30; j++) begin
                    set_y(sel, 1'($urandom_range(0, 1)));
                    @(posedge clk); #1;
                    grab(sel);
                    if (o_done || o_busy) saw_done = 1'b1;
                end
                check("abort_no_done", 32'(saw_done), 32'd0);
                check("abort_tt_hold", 32'(o_tt), 32'(mtt));
                return;
            end

            if (c == late_c) set_start(sel, 1'b1);
            // start during the DONE cycle must be ignored
            if (c == last) set_start(sel, 1'b1);
            if (smp) mtt[k] = func[k];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] f;
        logic [7:0] e;
        int         sel;
        int         ab;
        rst = 1'b1; abort = 1'b0; expected = 8'h00;
        start1 = 1'b0; start2 = 1'b0; y1 = 1'b0; y2 = 1'b0;
        #1;
        grab(0); check_zero("reset2");
        grab(1); check_zero("reset1");
        #20 rst = 1'b0;

        // Y = A & ~B & C is true only for vector 5
        scan(0, 8'h20, 8'h20, -1, 1'b0, -1, -1);
        scan(0, 8'hFF, 8'h20, -1, 1'b0, -1, -1);
        scan(0, 8'hFF, 8'hFF, 3, 1'b0, -1, -1);
        scan(0, 8'h20, 8'h20, -1, 1'b0, 10, -1);
        scan(0, 8'($urandom), 8'($urandom), -1, 1'b1, -1, 5);
        scan(0, 8'h5A, 8'h5A, -1, 1'b0, -1, -1);
        scan(1, 8'h00, 8'h00, -1, 1'b1, -1, -1);
        scan(1, 8'h81, 8'h81, 0, 1'b0, -1, -1);
        scan(1, 8'hFF, 8'hFF, 7, 1'b0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            sel = int'($urandom_range(0, 1));
            f   = 8'($urandom);
            e   = ($urandom_range(0, 1) != 0) ? f : 8'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            scan(sel, f, e, ab, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
